// File: rtl/m_table_mod_pipe_if.sv
// ---------------------------------------------------------------------------
// m_table_mod_pipe_if
//   Request/result bundle between the RNG, the rand-mod-m pipeline and the
//   unsat clause buffer read port.
//
//   Handshake (both channels): a transfer happens on a rising clk edge where
//   valid && ready. The source holds valid and its payload stable until that
//   edge. The sink's ready may depend combinationally on the sink's own state
//   but never on the source's valid.
//
//   Request channel : in_valid, in_ready, m_i, rand_i, id_i
//   Result channel  : out_valid, out_ready, idx_o, id_o, div_by_zero_o
//
//   Modports: master = request source / result sink (testbench, RNG side)
//             slave  = the pipeline
// ---------------------------------------------------------------------------
interface m_table_mod_pipe_if #(
  parameter int M_WIDTH    = 11,
  parameter int RAND_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [M_WIDTH-1:0]    m_i;
  logic [RAND_WIDTH-1:0] rand_i;
  logic [ID_WIDTH-1:0]   id_i;
  logic                  out_valid;
  logic                  out_ready;
  logic [M_WIDTH-1:0]    idx_o;
  logic [ID_WIDTH-1:0]   id_o;
  logic                  div_by_zero_o;

  modport master (
    output in_valid, m_i, rand_i, id_i, out_ready,
    input  in_ready, out_valid, idx_o, id_o, div_by_zero_o
  );

  modport slave (
    input  in_valid, m_i, rand_i, id_i, out_ready,
    output in_ready, out_valid, idx_o, id_o, div_by_zero_o
  );
endinterface

// File: rtl/m_table_mod_pipe.sv
// ---------------------------------------------------------------------------
// m_table_mod_pipe
//   Returns rand mod m as an index into the unsat clause buffer, using a
//   round-up reciprocal table, one multiply and a single-step correction.
//   One request per cycle, in-order results, tag carried through.
//
//   Pipeline (request sampled at edge N, result visible after edge N+3):
//     S1  reciprocal table read (synchronous ROM), m/rand/id captured
//     S2  q = (rand * recip) >> W
//     S3  remainder r = rand - q*m, kept as sign + low index bits
//     out correction (r < 0 -> r + m), result registers
//
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     bus (slave)              request / result handshake bundle
//     clear_debug_DIV_BY_ZERO  clears the sticky divide-by-zero flag
//     debug_DIV_BY_ZERO        sticky: a request with m == 0 was accepted
//     check_err_o              (M_TABLE_MOD_CHECK_EN only) sticky remainder
//                              range violation, cleared only by rst
//
//   Build option: define M_TABLE_MOD_CHECK_EN to add the remainder range
//   checker and the check_err_o port.
//
//   The table contents are generated at elaboration with the same rule as
//   the M_TABLE_NAME image (entry i = ceil(2^W/(i+1))), so no image file has
//   to travel with the netlist; the parameter keeps the image name visible.
// ---------------------------------------------------------------------------
module m_table_mod_pipe #(
  parameter int BUFFER_DEPTH  = 2048,
  parameter int M_TABLE_WIDTH = 32,
  parameter int RAND_WIDTH    = 32,
  parameter int ID_WIDTH      = 4,
  parameter     M_TABLE_NAME  = "M_table_roundup.mem"
) (
  input  logic                clk,
  input  logic                rst,
  m_table_mod_pipe_if.slave   bus,
  input  logic                clear_debug_DIV_BY_ZERO,
  output logic                debug_DIV_BY_ZERO
`ifdef M_TABLE_MOD_CHECK_EN
  ,
  output logic                check_err_o
`endif
);
  localparam int MW = $clog2(BUFFER_DEPTH);
  localparam int W  = M_TABLE_WIDTH;
  localparam int RW = RAND_WIDTH;
  localparam int IW = ID_WIDTH;

  if (RAND_WIDTH > M_TABLE_WIDTH) begin : g_bad_rand_width
    $error("m_table_mod_pipe: RAND_WIDTH must not exceed M_TABLE_WIDTH");
  end
  if (MW > RAND_WIDTH) begin : g_bad_depth
    $error("m_table_mod_pipe: index width must not exceed RAND_WIDTH");
  end
  if ($bits(M_TABLE_NAME) < 8) begin : g_bad_name
    $error("m_table_mod_pipe: M_TABLE_NAME must not be empty");
  end

  // ceil(2^W / (i+1)); entry 0 wraps to 0 and is never used downstream.
  function automatic logic [W-1:0] recip_entry(input int unsigned i);
    logic [W+1:0] num;
    num    = '0;
    num[W] = 1'b1;
    num    = num + (W+2)'(i);
    return W'(num / (W+2)'(i + 1));
  endfunction

  logic [W-1:0] rom [BUFFER_DEPTH];
  for (genvar g = 0; g < BUFFER_DEPTH; g++) begin : g_rom
    assign rom[g] = recip_entry(g);
  end

  // Pipeline state
  logic          s1_v, s2_v, s3_v, out_v;
  logic [MW-1:0] s1_m, s2_m, s3_m;
  logic [RW-1:0] s1_rand, s2_rand;
  logic [IW-1:0] s1_id, s2_id, s3_id, out_id;
  logic [W-1:0]  s1_recip;
  logic [RW-1:0] s2_q;
  logic          s3_neg;
  logic [MW-1:0] s3_r_lo;
  logic [MW-1:0] out_idx;
  logic          out_dbz;
  logic          dbz_sticky;

  // The whole pipe freezes while a result waits for the consumer.
  logic stall, accept;
  assign stall        = out_v && !bus.out_ready;
  assign bus.in_ready = !rst && !stall;
  assign accept       = bus.in_valid && bus.in_ready;

  logic [MW-1:0] rom_addr;
  assign rom_addr = (bus.m_i <= MW'(1)) ? '0 : bus.m_i - MW'(1);

  // Block-ROM style read register: no reset on the data.
  always_ff @(posedge clk) begin
    if (!stall) s1_recip <= rom[rom_addr];
  end

  // q*m can exceed rand by less than m, so the remainder is negative exactly
  // when q*m > rand. Only the low index bits of r are needed afterwards,
  // because the corrected remainder is known to lie in [0, m).
  logic [RW+MW-1:0] s2_qm;
  logic             s2_neg;
  logic [MW-1:0]    s2_r_lo;
  logic             s2_trivial;
  assign s2_qm      = {{MW{1'b0}}, s2_q} * {{RW{1'b0}}, s2_m};
  assign s2_neg     = {{MW{1'b0}}, s2_rand} < s2_qm;
  assign s2_r_lo    = s2_rand[MW-1:0] - s2_qm[MW-1:0];
  assign s2_trivial = (s2_m <= MW'(1));   // m = 0 or 1: result forced to 0

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v    <= 1'b0; s1_m  <= '0; s1_rand <= '0; s1_id <= '0;
      s2_v    <= 1'b0; s2_m  <= '0; s2_rand <= '0; s2_id <= '0; s2_q <= '0;
      s3_v    <= 1'b0; s3_m  <= '0; s3_id   <= '0; s3_neg <= 1'b0; s3_r_lo <= '0;
      out_v   <= 1'b0; out_idx <= '0; out_id <= '0; out_dbz <= 1'b0;
    end else if (!stall) begin
      s1_v    <= accept;
      s1_m    <= bus.m_i;
      s1_rand <= bus.rand_i;
      s1_id   <= bus.id_i;

      s2_v    <= s1_v;
      s2_m    <= s1_m;
      s2_rand <= s1_rand;
      s2_id   <= s1_id;
      s2_q    <= RW'(({{W{1'b0}}, s1_rand} * {{RW{1'b0}}, s1_recip}) >> W);

      s3_v    <= s2_v;
      s3_m    <= s2_m;
      s3_id   <= s2_id;
      s3_neg  <= s2_trivial ? 1'b0 : s2_neg;
      s3_r_lo <= s2_trivial ? '0 : s2_r_lo;

      out_v   <= s3_v;
      out_idx <= s3_r_lo + (s3_neg ? s3_m : '0);
      out_id  <= s3_id;
      out_dbz <= s3_v && (s3_m == '0);
    end
  end

  // Sticky flag keeps working through stalls; a same-cycle set beats clear.
  always_ff @(posedge clk) begin
    if (rst)                                dbz_sticky <= 1'b0;
    else if (accept && (bus.m_i == '0))     dbz_sticky <= 1'b1;
    else if (clear_debug_DIV_BY_ZERO)       dbz_sticky <= 1'b0;
  end

  assign bus.out_valid     = out_v;
  assign bus.idx_o         = out_idx;
  assign bus.id_o          = out_id;
  assign bus.div_by_zero_o = out_dbz;
  assign debug_DIV_BY_ZERO = dbz_sticky;

`ifdef M_TABLE_MOD_CHECK_EN
  // Full-width remainder shadow, checked after the correction: 0 <= r < m.
  logic [RW:0] s2_r_full, s3_r_full, s3_r_fix;
  logic        chk_bad;
  logic        chk_err_q;
  assign s2_r_full = {1'b0, s2_rand} - s2_qm[RW:0];
  assign s3_r_fix  = s3_r_full + (s3_neg ? {{(RW+1-MW){1'b0}}, s3_m} : '0);
  assign chk_bad   = s3_v && (s3_m != '0) &&
                     (s3_r_fix[RW] || (s3_r_fix >= {{(RW+1-MW){1'b0}}, s3_m}));

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_r_full <= '0;
      chk_err_q <= 1'b0;
    end else if (!stall) begin
      s3_r_full <= s2_trivial ? '0 : s2_r_full;
      if (chk_bad) chk_err_q <= 1'b1;
    end
  end
  assign check_err_o = chk_err_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && !stall && chk_bad)
      $error("m_table_mod_pipe: remainder out of range (m=%0d)", s3_m);
  end
`endif
`endif
endmodule

// File: tb/tb_m_table_mod_pipe.sv
// ---------------------------------------------------------------------------
// tb_m_table_mod_pipe
//   Table-driven vectors with exact-latency checks, hand-written sequences
//   for the sticky flag and reset flush, then randomized traffic with a
//   randomly toggling out_ready checked by a scoreboard whose expected values
//   come from plain rand % m arithmetic.
// ---------------------------------------------------------------------------
module tb_m_table_mod_pipe;
  localparam int BD = 2048;
  localparam int MW = 11;
  localparam int RW = 32;
  localparam int IW = 4;
  localparam int W  = 32;
  localparam int EW = 1 + IW + MW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear_dbz = 1'b0;
  logic debug_dbz;
`ifdef M_TABLE_MOD_CHECK_EN
  logic check_err;
`endif

  always #5 clk = ~clk;

  m_table_mod_pipe_if #(.M_WIDTH(MW), .RAND_WIDTH(RW), .ID_WIDTH(IW)) bus ();

  m_table_mod_pipe #(
    .BUFFER_DEPTH (BD),
    .M_TABLE_WIDTH(W),
    .RAND_WIDTH   (RW),
    .ID_WIDTH     (IW),
    .M_TABLE_NAME ("M_table_roundup.mem")
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .bus                    (bus.slave),
    .clear_debug_DIV_BY_ZERO(clear_dbz),
    .debug_DIV_BY_ZERO      (debug_dbz)
`ifdef M_TABLE_MOD_CHECK_EN
    ,
    .check_err_o            (check_err)
`endif
  );

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  bit sb_en = 1'b0;
  bit rand_ready_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: {div_by_zero, id, rand mod m} from plain arithmetic.
  function automatic logic [EW-1:0] model(input logic [MW-1:0] m, input logic [RW-1:0] r,
                                         input logic [IW-1:0] id);
    longint unsigned rr, mm;
    logic [MW-1:0] idx;
    rr = r;
    mm = m;
    if (mm == 0) idx = '0;
    else         idx = MW'(rr % mm);
    return {(mm == 0), id, idx};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [MW-1:0] m;
    logic [RW-1:0] r;
    logic [IW-1:0] id;
    logic [MW-1:0] exp_idx;
    logic          exp_dbz;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs[NVEC];

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    bus.in_valid = 1'b1;
    bus.m_i      = v.m;
    bus.rand_i   = v.r;
    bus.id_i     = v.id;
    @(negedge clk);
    check($sformatf("vec%0d_in_ready", i), bus.in_ready, 1);
    @(posedge clk); #1;                       // accepted at edge N
    bus.in_valid = 1'b0;
    @(posedge clk); #1;                       // N+1
    @(posedge clk); #1;                       // N+2
    check($sformatf("vec%0d_not_early", i), bus.out_valid, 0);
    @(posedge clk); #1;                       // N+3
    check($sformatf("vec%0d_valid", i), bus.out_valid, 1);
    check($sformatf("vec%0d_idx", i), bus.idx_o, v.exp_idx);
    check($sformatf("vec%0d_id", i), bus.id_o, v.id);
    check($sformatf("vec%0d_dbz", i), bus.div_by_zero_o, v.exp_dbz);
    @(posedge clk); #1;                       // consumed (out_ready = 1)
  endtask

  // ---------------- random driver ----------------
  task automatic run_random(input int n, input int gap_pct);
    for (int k = 0; k < n; k++) begin
      logic [MW-1:0] m;
      logic [RW-1:0] r;
      int sel, waited;
      sel = $urandom_range(0, 19);
      if (sel == 0)      m = '0;
      else if (sel == 1) m = MW'(1);
      else if (sel == 2) m = MW'(BD - 1);
      else               m = MW'($urandom_range(1, BD - 1));
      sel = $urandom_range(0, 9);
      if (sel == 0)      r = '1;
      else if (sel == 1) r = '0;
      else               r = $urandom;
      if ($urandom_range(0, 99) < gap_pct) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.m_i      = m;
      bus.rand_i   = r;
      bus.id_i     = IW'(k);
      waited = 0;
      forever begin
        @(negedge clk);
        if (bus.in_ready) break;
        waited++;
        if (waited > 200) break;
      end
      if (!bus.in_ready) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout: got in_ready=0 for 200 cycles expected acceptance");
        bus.in_valid = 1'b0;
        return;
      end
      exp_q.push_back(model(m, r, IW'(k)));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- out_ready randomizer ----------------
  initial begin
    forever begin
      @(posedge clk); #2;
      if (rand_ready_en) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin : monitor
    logic          stall_now;
    logic          prev_stall;
    logic [EW-1:0] got, held, e;
    prev_stall = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (sb_en && !rst) begin
        stall_now = bus.out_valid && !bus.out_ready;
        got = {bus.div_by_zero_o, bus.id_o, bus.idx_o};
        check("in_ready_vs_stall", bus.in_ready, !stall_now);
        if (prev_stall) begin
          check("hold_valid", bus.out_valid, 1);
          check("hold_data", got, held);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result: got 0x%0h expected no result", got);
          end else begin
            e = exp_q.pop_front();
            check("result", got, e);
          end
        end
        prev_stall = stall_now;
        held       = got;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish within 90000 cycles");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int cnt;
    vecs[0]  = '{MW'(7),    32'd100,        4'd3,  MW'(2),    1'b0};
    vecs[1]  = '{MW'(2047), 32'hFFFF_FFFF,  4'd4,  MW'(1023), 1'b0};
    vecs[2]  = '{MW'(1),    32'h1234_5678,  4'd5,  MW'(0),    1'b0};
    vecs[3]  = '{MW'(0),    32'd5,          4'd6,  MW'(0),    1'b1};
    vecs[4]  = '{MW'(2),    32'hFFFF_FFFF,  4'd7,  MW'(1),    1'b0};
    vecs[5]  = '{MW'(1000), 32'd123456,     4'd8,  MW'(456),  1'b0};
    vecs[6]  = '{MW'(3),    32'd0,          4'd9,  MW'(0),    1'b0};
    vecs[7]  = '{MW'(1024), 32'hDEAD_BEEF,  4'd10, MW'(751),  1'b0};
    vecs[8]  = '{MW'(10),   32'd1234567,    4'd11, MW'(7),    1'b0};
    vecs[9]  = '{MW'(2047), 32'd2046,       4'd12, MW'(2046), 1'b0};
    vecs[10] = '{MW'(2047), 32'd2047,       4'd13, MW'(0),    1'b0};
    vecs[11] = '{MW'(6),    32'hFFFF_FFFF,  4'd14, MW'(3),    1'b0};

    bus.in_valid  = 1'b0;
    bus.m_i       = '0;
    bus.rand_i    = '0;
    bus.id_i      = '0;
    bus.out_ready = 1'b1;

    // Reset
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_idx", bus.idx_o, 0);
    check("rst_id", bus.id_o, 0);
    check("rst_dbz", bus.div_by_zero_o, 0);
    check("rst_debug_dbz", debug_dbz, 0);
    check("post_rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;

    // Table-driven vectors, one at a time, exact latency
    for (int i = 0; i < NVEC; i++) run_vec(i);

    // Sticky divide-by-zero flag
    check("sticky_after_m0", debug_dbz, 1);
    repeat (2) @(posedge clk);
    #1 check("sticky_holds", debug_dbz, 1);
    clear_dbz = 1'b1;
    @(posedge clk); #1;
    clear_dbz = 1'b0;
    check("sticky_cleared", debug_dbz, 0);
    clear_dbz    = 1'b1;
    bus.in_valid = 1'b1;
    bus.m_i      = '0;
    bus.rand_i   = 32'd9;
    bus.id_i     = 4'd2;
    @(posedge clk); #1;
    clear_dbz    = 1'b0;
    bus.in_valid = 1'b0;
    check("sticky_set_wins", debug_dbz, 1);
    repeat (3) @(posedge clk);
    #1;
    check("m0_result_valid", bus.out_valid, 1);
    check("m0_result_dbz", bus.div_by_zero_o, 1);
    check("m0_result_idx", bus.idx_o, 0);
    clear_dbz = 1'b1;
    @(posedge clk); #1;
    clear_dbz = 1'b0;
    check("sticky_cleared2", debug_dbz, 0);

    // Reset flush with three requests in flight
    for (int j = 0; j < 3; j++) begin
      bus.in_valid = 1'b1;
      bus.m_i      = MW'(7);
      bus.rand_i   = RW'(100 + j);
      bus.id_i     = IW'(j);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    check("flush_pre_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      check($sformatf("flush_quiet%0d", j), bus.out_valid, 0);
      @(posedge clk); #1;
    end
    check("flush_in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.m_i      = MW'(9);
    bus.rand_i   = 32'd50;
    bus.id_i     = 4'd10;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cnt = 0;
    while (cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
      if (bus.out_valid) break;
    end
    check("flush_latency", cnt, 3);
    check("flush_idx", bus.idx_o, 5);
    check("flush_id", bus.id_o, 10);
    @(posedge clk); #1;

    // Randomized traffic against the reference model
    sb_en = 1'b1;
    rand_ready_en = 1'b1;
    run_random(16, 0);
    drain();
    run_random(3000, 10);
    drain();
    rand_ready_en = 1'b0;
    sb_en = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
`ifdef M_TABLE_MOD_CHECK_EN
    check("check_err_clear", check_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
